// File: rtl/weight_stream_loader.sv
// Weight tile streamer: base/stride/count/repeat BRAM read sequencer feeding a
// credit-limited first-word-fall-through skid FIFO towards the PE array.
module weight_stream_loader #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 128,
   parameter int BUF_ADDR_W = 15,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter bit PRELOAD_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [BUF_ADDR_W-1:0] cfg_base,
   input  logic [BUF_ADDR_W-1:0] cfg_stride,
   input  logic [16:0]           cfg_count,
   input  logic [7:0]            cfg_repeat,
   input  logic [ADDR_W-1:0]     cfg_ext_base,
   output logic                  busy,
   output logic                  done,
   output logic                  preload_req,
   output logic [ADDR_W-1:0]     preload_base,
   output logic [16:0]           preload_count,
   input  logic                  preload_done,
   output logic                  bmg_en,
   output logic [BUF_ADDR_W-1:0] bmg_addr,
   input  logic [DATA_W-1:0]     bmg_data,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_last,
   input  logic                  out_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_PRELOAD, S_READ, S_DRAIN} state_t;

   state_t                state_q, state_d;
   logic                  start_q;
   logic [BUF_ADDR_W-1:0] base_q, stride_q, addr_q, addr_d;
   logic [16:0]           count_q, word_q, word_d;
   logic [7:0]            repeat_q, pass_q, pass_d;
   logic [ADDR_W-1:0]     ext_base_q;
   logic                  busy_q, busy_d, done_q, done_d;
   logic [RD_LAT-1:0]     pipe_vld_q, pipe_last_q;
   logic [DATA_W-1:0]     fifo_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last_q;
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]      fifo_cnt_q, inflight;
   logic                  start_rise, load, flush, issue, issue_last, credit, push, pop;

   assign start_rise = start & ~start_q;
   assign load       = start_rise && (state_q == S_IDLE);
   assign flush      = abort && (state_q != S_IDLE);
   assign issue_last = (word_q == count_q - 17'd1);
   assign push       = pipe_vld_q[RD_LAT-1];
   assign pop        = out_valid & out_ready;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + OCC_W'(pipe_vld_q[i]);
   end

   // Every word already requested owns a FIFO slot, so landing data can never overflow.
   assign credit = ({1'b0, inflight} + {1'b0, fifo_cnt_q}) < (OCC_W + 1)'(FIFO_DEPTH);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      addr_d      = addr_q;
      word_d      = word_q;
      pass_d      = pass_q;
      issue       = 1'b0;
      preload_req = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_rise) begin
               busy_d = 1'b1;
               addr_d = cfg_base;
               word_d = '0;
               pass_d = '0;
               if (cfg_count == 17'd0) state_d = S_DRAIN;
               else if (PRELOAD_EN)    state_d = S_PRELOAD;
               else                    state_d = S_READ;
            end
         end
         S_PRELOAD: begin
            preload_req = 1'b1;
            if (preload_done) state_d = S_READ;
         end
         S_READ: begin
            if (credit) begin
               issue = 1'b1;
               if (issue_last) begin
                  word_d = '0;
                  addr_d = base_q;
                  pass_d = pass_q + 8'd1;
                  if (pass_q == repeat_q - 8'd1) state_d = S_DRAIN;
               end else begin
                  word_d = word_q + 17'd1;
                  addr_d = addr_q + stride_q;
               end
            end
         end
         S_DRAIN: begin
            if (inflight == '0 && fifo_cnt_q == '0) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d     = S_IDLE;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         issue       = 1'b0;
         preload_req = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= S_IDLE;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         addr_q     <= '0;
         word_q     <= '0;
         pass_q     <= '0;
         base_q     <= '0;
         stride_q   <= '0;
         count_q    <= '0;
         repeat_q   <= '0;
         ext_base_q <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         busy_q  <= busy_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         pass_q  <= pass_d;
         if (load) begin
            base_q     <= cfg_base;
            stride_q   <= cfg_stride;
            count_q    <= cfg_count;
            repeat_q   <= (cfg_repeat == 8'd0) ? 8'd1 : cfg_repeat;
            ext_base_q <= cfg_ext_base;
         end
      end
   end

   // Tag pipe mirrors the BRAM latency; clearing it on abort discards in-flight returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
         fifo_last_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
      end else if (flush) begin
         pipe_vld_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         pipe_vld_q[0]  <= issue;
         pipe_last_q[0] <= issue_last;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_last_q[i] <= pipe_last_q[i-1];
         end
         if (push) begin
            fifo_last_q[wr_ptr_q] <= pipe_last_q[RD_LAT-1];
            wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + OCC_W'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - OCC_W'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   // NOTE: the data array is deliberately not reset; occupancy is tracked by fifo_cnt_q.
   always_ff @(posedge clk) begin
      if (push && !flush) fifo_mem[wr_ptr_q] <= bmg_data;
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign preload_base  = ext_base_q;
   assign preload_count = count_q;
   assign bmg_en        = issue;
   assign bmg_addr      = addr_q;
   assign out_valid     = (fifo_cnt_q != '0);
   assign out_data      = out_valid ? fifo_mem[rd_ptr_q] : '0;
   assign out_last      = out_valid & fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_weight_stream_loader.sv
// Randomised self-checking bench for weight_stream_loader: a list-based job model
// and a latency-accurate BRAM model check addresses, beats, credits and handshakes.
module tb_weight_stream_loader;

   localparam int ADDR_W     = 19;
   localparam int DATA_W     = 128;
   localparam int BUF_ADDR_W = 15;
   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  start = 1'b0;
   logic                  abort = 1'b0;
   logic [BUF_ADDR_W-1:0] cfg_base = '0;
   logic [BUF_ADDR_W-1:0] cfg_stride = '0;
   logic [16:0]           cfg_count = '0;
   logic [7:0]            cfg_repeat = '0;
   logic [ADDR_W-1:0]     cfg_ext_base = '0;
   logic                  preload_done = 1'b0;
   logic [DATA_W-1:0]     bmg_data = '0;
   logic                  out_ready = 1'b0;
   logic                  busy, done, preload_req, bmg_en, out_valid, out_last;
   logic [ADDR_W-1:0]     preload_base;
   logic [16:0]           preload_count;
   logic [BUF_ADDR_W-1:0] bmg_addr;
   logic [DATA_W-1:0]     out_data;

   weight_stream_loader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_ADDR_W(BUF_ADDR_W),
      .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .PRELOAD_EN(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_count(cfg_count),
      .cfg_repeat(cfg_repeat), .cfg_ext_base(cfg_ext_base),
      .busy(busy), .done(done), .preload_req(preload_req),
      .preload_base(preload_base), .preload_count(preload_count),
      .preload_done(preload_done), .bmg_en(bmg_en), .bmg_addr(bmg_addr),
      .bmg_data(bmg_data), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Each BRAM word is a recognisable function of its address.
   function automatic logic [127:0] wdata(input logic [14:0] a);
      return {8{1'b0, a}} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   endfunction

   // BRAM: a read enabled in cycle T shows its word during cycle T+RD_LAT, garbage otherwise.
   logic        sh_en   [0:RD_LAT];
   logic [14:0] sh_addr [0:RD_LAT];
   initial begin
      for (int i = 0; i <= RD_LAT; i++) begin sh_en[i] = 1'b0; sh_addr[i] = '0; end
      forever begin
         @(negedge clk);
         for (int i = RD_LAT; i > 0; i--) begin sh_en[i] = sh_en[i-1]; sh_addr[i] = sh_addr[i-1]; end
         sh_en[0]   = bmg_en;
         sh_addr[0] = bmg_addr;
         bmg_data   = sh_en[RD_LAT] ? wdata(sh_addr[RD_LAT]) : {$urandom, $urandom, $urandom, $urandom};
      end
   end

   // Preload engine: answers on the pl_delay-th cycle of a request.
   int pl_delay = 1;
   int pl_cnt   = 0;
   initial forever begin
      @(negedge clk);
      if (preload_req) begin
         pl_cnt++;
         preload_done = (pl_cnt >= pl_delay);
      end else begin
         pl_cnt       = 0;
         preload_done = 1'b0;
      end
   end

   // Reference: flat lists of expected read addresses and {last, data} beats for the job.
   logic [14:0]  exp_addr [$];
   logic [128:0] exp_beat [$];
   logic [128:0] mon_e;
   bit           mon_en = 1'b0;
   int issues, beats, done_cnt, done_cyc, first_issue, last_issue, first_beat, req_run, req_len;
   int job_count;
   logic [ADDR_W-1:0] job_ext;
   logic         prev_stall = 1'b0, prev_abort = 1'b0, prev_last = 1'b0;
   logic [127:0] prev_data = '0;

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         check("no_issue_in_preload", 128'(bmg_en && preload_req), 128'(0));
         if (bmg_en) begin
            if (issues == 0) first_issue = cyc;
            last_issue = cyc;
            issues++;
            check("issue_expected", 128'(exp_addr.size() > 0), 128'(1));
            if (exp_addr.size() > 0) check("rd_addr", 128'(bmg_addr), 128'(exp_addr.pop_front()));
            check("credit_limit", 128'(issues - beats <= FIFO_DEPTH), 128'(1));
         end
         if (preload_req) begin
            req_run++;
            check("pl_count", 128'(preload_count), 128'(job_count));
            check("pl_base", 128'(preload_base), 128'(job_ext));
         end else if (req_run != 0) begin
            req_len = req_run;
            req_run = 0;
         end
         if (prev_stall && !prev_abort) begin
            check("stall_valid", 128'(out_valid), 128'(1));
            check("stall_data", out_data, prev_data);
            check("stall_last", 128'(out_last), 128'(prev_last));
         end
         if (out_valid && out_ready) begin
            if (beats == 0) first_beat = cyc;
            check("beat_expected", 128'(exp_beat.size() > 0), 128'(1));
            if (exp_beat.size() > 0) begin
               mon_e = exp_beat.pop_front();
               check("beat_data", out_data, mon_e[127:0]);
               check("beat_last", 128'(out_last), 128'(mon_e[128]));
            end
            beats++;
         end
         if (done) begin done_cnt++; done_cyc = cyc; end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         prev_abort = abort;
      end
   end

   task automatic run_job(input logic [14:0] base, input logic [14:0] stride, input int count,
                          input int rep, input int pdly, input int rmode, input int abort_at,
                          input bit second_start);
      int reps, total, budget, ab_cyc, start_cyc, tail;
      bit aborted, finished;
      logic [14:0] a;
      reps  = (rep == 0) ? 1 : rep;
      total = count * reps;
      @(posedge clk); #1;
      exp_addr.delete();
      exp_beat.delete();
      for (int p = 0; p < reps; p++) begin
         for (int i = 0; i < count; i++) begin
            a = 15'((int'(base) + i * int'(stride)) % 32768);
            exp_addr.push_back(a);
            exp_beat.push_back({(i == count - 1), wdata(a)});
         end
      end
      issues = 0; beats = 0; done_cnt = 0; done_cyc = 0; req_run = 0; req_len = 0;
      first_issue = 0; last_issue = 0; first_beat = 0;
      prev_stall = 1'b0; prev_abort = 1'b0;
      job_count = count;
      job_ext   = 19'($urandom);
      pl_delay  = pdly;
      cfg_base = base; cfg_stride = stride; cfg_count = 17'(count);
      cfg_repeat = 8'(rep); cfg_ext_base = job_ext;
      start = 1'b1;
      out_ready = 1'b0;
      start_cyc = cyc;
      mon_en = 1'b1;
      aborted = 1'b0; finished = 1'b0; ab_cyc = 0; tail = 0;
      budget = 100 + 4 * total + pdly;
      for (int k = 1; k <= budget; k++) begin
         @(posedge clk); #1;
         start = second_start && (k == 6);
         abort = 1'b0;
         cfg_base = 15'($urandom); cfg_stride = 15'($urandom);
         cfg_count = 17'($urandom_range(0, 40)); cfg_repeat = 8'($urandom);
         cfg_ext_base = 19'($urandom);
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (k % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (k == 1) check("busy_set", 128'(busy), 128'(1));
         if (aborted && k == ab_cyc + 1) begin
            exp_addr.delete();
            exp_beat.delete();
            @(negedge clk);
            check("abort_busy", 128'(busy), 128'(0));
            check("abort_bmg_en", 128'(bmg_en), 128'(0));
            check("abort_out_valid", 128'(out_valid), 128'(0));
            check("abort_preload_req", 128'(preload_req), 128'(0));
         end
         if (abort_at >= 0 && !aborted && beats == abort_at) begin
            abort = 1'b1;
            out_ready = 1'b0;
            aborted = 1'b1;
            ab_cyc = k;
         end
         if (!aborted && done_cnt > 0 && tail == 0) tail = k;
         if ((tail != 0 && k >= tail + 3) || (aborted && k >= ab_cyc + 20)) begin
            finished = 1'b1;
            break;
         end
      end
      abort = 1'b0;
      start = 1'b0;
      check("job_finished", 128'(finished), 128'(1));
      check("addr_left", 128'(exp_addr.size()), 128'(0));
      check("beats_left", 128'(exp_beat.size()), 128'(0));
      check("busy_after", 128'(busy), 128'(0));
      if (aborted) begin
         check("abort_beats", 128'(beats), 128'(abort_at));
         check("abort_no_done", 128'(done_cnt), 128'(0));
      end else begin
         check("beat_count", 128'(beats), 128'(total));
         check("done_count", 128'(done_cnt), 128'(1));
      end
      check("preload_len", 128'(req_len), 128'((count > 0) ? pdly : 0));
      if (count == 0) begin
         check("zero_done_lat", 128'(done_cyc - start_cyc), 128'(2));
         check("zero_issues", 128'(issues), 128'(0));
      end
      if (rmode == 0 && count > 0 && !aborted) begin
         check("issue_burst", 128'(last_issue - first_issue), 128'(total - 1));
         check("first_beat_lat", 128'(first_beat - first_issue), 128'(RD_LAT + 1));
      end
      mon_en = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_preload_req", 128'(preload_req), 128'(0));
      check("rst_preload_base", 128'(preload_base), 128'(0));
      check("rst_preload_count", 128'(preload_count), 128'(0));
      check("rst_bmg_en", 128'(bmg_en), 128'(0));
      check("rst_bmg_addr", 128'(bmg_addr), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_data", out_data, 128'(0));
      check("rst_out_last", 128'(out_last), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      run_job(15'h0010, 15'd1, 8, 1, 3, 0, -1, 1'b0);
      run_job(15'h7FFE, 15'd3, 4, 1, 2, 0, -1, 1'b0);
      run_job(15'h0000, 15'd1, 16, 1, 2, 1, -1, 1'b0);
      run_job(15'h0100, 15'd5, 5, 3, 1, 0, -1, 1'b0);
      run_job(15'h0020, 15'd1, 4, 1, 20, 0, -1, 1'b0);
      run_job(15'h0040, 15'd2, 32, 1, 1, 0, 3, 1'b0);
      run_job(15'h0300, 15'd7, 6, 1, 2, 2, -1, 1'b0);
      run_job(15'h0050, 15'd1, 0, 1, 4, 0, -1, 1'b0);
      run_job(15'h0060, 15'd1, 12, 2, 3, 2, -1, 1'b1);
      run_job(15'h0070, 15'd4, 6, 0, 2, 0, -1, 1'b0);

      // Reset in the middle of a job: everything drops at once and no done follows.
      @(posedge clk); #1;
      pl_delay = 2;
      cfg_base = 15'h0200; cfg_stride = 15'd1; cfg_count = 17'd20; cfg_repeat = 8'd1;
      out_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_busy", 128'(busy), 128'(0));
      check("midrst_out_valid", 128'(out_valid), 128'(0));
      check("midrst_bmg_en", 128'(bmg_en), 128'(0));
      check("midrst_preload_req", 128'(preload_req), 128'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("midrst_no_done", 128'(done), 128'(0));
      end

      for (int r = 0; r < 8; r++) begin
         run_job(15'($urandom), 15'($urandom), $urandom_range(1, 20), $urandom_range(0, 3),
                 $urandom_range(1, 6), $urandom_range(0, 2), -1, 1'b0);
      end
      run_job(15'h0500, 15'd1, 32, 2, 2, 0, 3, 1'b0);
      run_job(15'h0600, 15'd9, 10, 1, 1, 0, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
